// File: rtl/wm8731_cfg_scheduler_if.sv
// ---------------------------------------------------------------------------
// wm8731_cfg_scheduler_if
// Bundles the runtime request/ack handshake and the I2C frame transmitter
// handshake used by wm8731_cfg_scheduler.
//   i_req[1:0]       requester levels (0 = volume, 1 = mute/mode)
//   i_req_data0/1    requester payloads {reg[6:0], data[8:0]}
//   o_ack[1:0]       per-requester completion pulse
//   o_tx_start       frame launch pulse to the transmitter
//   o_tx_data        24-bit frame {dev_addr, reg, data}
//   i_tx_done        transmitter finished pulse
//   i_tx_nack        codec NACK, qualified by i_tx_done
// Signal prefixes are from the scheduler's point of view.
// master: the scheduler. slave: the requesters + transmitter side.
// ---------------------------------------------------------------------------
interface wm8731_cfg_scheduler_if;
    logic [1:0]  i_req;
    logic [15:0] i_req_data0;
    logic [15:0] i_req_data1;
    logic [1:0]  o_ack;
    logic        o_tx_start;
    logic [23:0] o_tx_data;
    logic        i_tx_done;
    logic        i_tx_nack;

    modport master (
        input  i_req, i_req_data0, i_req_data1, i_tx_done, i_tx_nack,
        output o_ack, o_tx_start, o_tx_data
    );

    modport slave (
        output i_req, i_req_data0, i_req_data1, i_tx_done, i_tx_nack,
        input  o_ack, o_tx_start, o_tx_data
    );
endinterface

// File: rtl/wm8731_cfg_scheduler.sv
// ---------------------------------------------------------------------------
// wm8731_cfg_scheduler
// Serialises all WM8731 configuration writes onto one I2C frame transmitter:
// first a fixed 7-entry power-up table (after i_start), then round-robin
// runtime writes from two requesters. NACKed or timed-out frames are retried
// up to MAX_RETRY extra times; a frame that exhausts its retries sets the
// sticky o_err and is still completed (acked) so requesters never stall.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          kicks off the init table (only honoured in IDLE)
//   o_init_done      high once all init frames are processed
//   o_busy           high outside IDLE and READY
//   o_err            sticky frame failure flag
//   bus              request/ack + transmitter handshake (master side)
// ---------------------------------------------------------------------------
module wm8731_cfg_scheduler #(
    parameter logic [7:0] DEV_ADDR    = 8'h34,
    parameter int         MAX_RETRY   = 2,
    parameter int         GAP_CYC     = 4,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    output logic                          o_init_done,
    output logic                          o_busy,
    output logic                          o_err,
    wm8731_cfg_scheduler_if.master        bus
);

    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [2:0] INIT_LAST = 3'd6;
    localparam logic [2:0] INIT_END  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_GAP,
        S_READY
    } state_t;

    typedef enum logic [1:0] {
        SRC_INIT,
        SRC_REQ0,
        SRC_REQ1
    } src_t;

    // Power-up table, {reg[6:0], data[8:0]}
    function automatic logic [15:0] init_entry(input logic [2:0] i);
        logic [15:0] e;
        e = 16'h0000;
        case (i)
            3'd0:    e = {7'h0F, 9'h000};  // reset
            3'd1:    e = {7'h04, 9'h015};  // analogue path
            3'd2:    e = {7'h05, 9'h000};  // digital path
            3'd3:    e = {7'h06, 9'h000};  // power down control
            3'd4:    e = {7'h07, 9'h042};  // interface format
            3'd5:    e = {7'h08, 9'h019};  // sampling control
            3'd6:    e = {7'h09, 9'h001};  // activate
            default: e = 16'h0000;
        endcase
        return e;
    endfunction

    // Registered state
    state_t            state;
    src_t              src;
    logic [2:0]        idx;
    logic [RTY_W-1:0]  retry_cnt;
    logic              retry_pend;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              rr_prio;     // requester that wins a tie
    logic [15:0]       payload;
    logic              tx_start;
    logic [23:0]       tx_data;
    logic [1:0]        ack;
    logic              init_done;
    logic              err;

    // Next-state values
    state_t            state_n;
    src_t              src_n;
    logic [2:0]        idx_n;
    logic [RTY_W-1:0]  retry_cnt_n;
    logic              retry_pend_n;
    logic [GAP_W-1:0]  gap_cnt_n;
    logic [TMO_W-1:0]  tmo_cnt_n;
    logic              rr_prio_n;
    logic [15:0]       payload_n;
    logic              tx_start_n;
    logic [23:0]       tx_data_n;
    logic [1:0]        ack_n;
    logic              init_done_n;
    logic              err_n;

    logic              grant_vld;
    logic              grant_id;
    logic              tx_fail;
    logic              tmo_hit;

    // Tie goes to rr_prio; a lone requester always wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        case (bus.i_req)
            2'b01:   begin grant_vld = 1'b1; grant_id = 1'b0;    end
            2'b10:   begin grant_vld = 1'b1; grant_id = 1'b1;    end
            2'b11:   begin grant_vld = 1'b1; grant_id = rr_prio; end
            default: begin grant_vld = 1'b0; grant_id = 1'b0;    end
        endcase
    end

    // Timeout fires on the TIMEOUT_CYC-th WAIT cycle and is folded into the
    // NACK path; a real done on that same cycle takes precedence.
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign tx_fail = (bus.i_tx_done && bus.i_tx_nack) || (!bus.i_tx_done && tmo_hit);

    always_comb begin
        state_n      = state;
        src_n        = src;
        idx_n        = idx;
        retry_cnt_n  = retry_cnt;
        retry_pend_n = retry_pend;
        gap_cnt_n    = gap_cnt;
        tmo_cnt_n    = tmo_cnt;
        rr_prio_n    = rr_prio;
        payload_n    = payload;
        tx_start_n   = 1'b0;
        tx_data_n    = tx_data;
        ack_n        = 2'b00;
        init_done_n  = init_done;
        err_n        = err;

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_n = S_ISSUE;
                    src_n   = SRC_INIT;
                    idx_n   = 3'd0;
                end
            end

            S_ISSUE: begin
                tx_data_n    = {DEV_ADDR, (src == SRC_INIT) ? init_entry(idx) : payload};
                tx_start_n   = 1'b1;
                tmo_cnt_n    = '0;
                retry_pend_n = 1'b0;
                state_n      = S_WAIT;
            end

            S_WAIT: begin
                if (bus.i_tx_done && !bus.i_tx_nack) begin
                    state_n = S_DONE;
                end else if (tx_fail) begin
                    if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                        // Same frame again after a gap; source/idx untouched.
                        retry_cnt_n  = retry_cnt + RTY_W'(1);
                        retry_pend_n = 1'b1;
                        gap_cnt_n    = '0;
                        state_n      = S_GAP;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_DONE;
                    end
                end else begin
                    tmo_cnt_n = tmo_cnt + TMO_W'(1);
                end
            end

            S_DONE: begin
                retry_cnt_n = '0;
                gap_cnt_n   = '0;
                state_n     = S_GAP;
                case (src)
                    SRC_INIT: begin
                        idx_n = idx + 3'd1;
                        if (idx == INIT_LAST) init_done_n = 1'b1;
                    end
                    SRC_REQ0: ack_n = 2'b01;
                    SRC_REQ1: ack_n = 2'b10;
                    default:  ack_n = 2'b00;
                endcase
            end

            S_GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                    if (retry_pend || (src == SRC_INIT && idx != INIT_END))
                        state_n = S_ISSUE;
                    else
                        state_n = S_READY;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end

            S_READY: begin
                if (grant_vld) begin
                    src_n     = grant_id ? SRC_REQ1 : SRC_REQ0;
                    payload_n = grant_id ? bus.i_req_data1 : bus.i_req_data0;
                    rr_prio_n = ~grant_id;
                    state_n   = S_ISSUE;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            src        <= SRC_INIT;
            idx        <= 3'd0;
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
            gap_cnt    <= '0;
            tmo_cnt    <= '0;
            rr_prio    <= 1'b0;
            payload    <= 16'h0000;
            tx_start   <= 1'b0;
            tx_data    <= 24'h000000;
            ack        <= 2'b00;
            init_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            src        <= src_n;
            idx        <= idx_n;
            retry_cnt  <= retry_cnt_n;
            retry_pend <= retry_pend_n;
            gap_cnt    <= gap_cnt_n;
            tmo_cnt    <= tmo_cnt_n;
            rr_prio    <= rr_prio_n;
            payload    <= payload_n;
            tx_start   <= tx_start_n;
            tx_data    <= tx_data_n;
            ack        <= ack_n;
            init_done  <= init_done_n;
            err        <= err_n;
        end
    end

    assign o_busy         = (state != S_IDLE) && (state != S_READY);
    assign o_init_done    = init_done;
    assign o_err          = err;
    assign bus.o_ack      = ack;
    assign bus.o_tx_start = tx_start;
    assign bus.o_tx_data  = tx_data;

endmodule

// File: tb/tb_wm8731_cfg_scheduler.sv
// ---------------------------------------------------------------------------
// tb_wm8731_cfg_scheduler
// Directed bench: a transmitter model answers each frame LAT cycles after the
// start pulse (optionally NACKing a chosen frame, or staying silent), and a
// negedge monitor logs starts, dones, acks and the o_init_done rise with a
// cycle stamp. Stimulus compares those logs against hand-computed frames.
// ---------------------------------------------------------------------------
module tb_wm8731_cfg_scheduler;

    localparam int LAT = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic init_done, busy, err;

    wm8731_cfg_scheduler_if bus();

    wm8731_cfg_scheduler dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .o_init_done (init_done),
        .o_busy      (busy),
        .o_err       (err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Monitor / model state (written only by the negedge process)
    int          cyc = 0;
    logic [23:0] frame_log [64];
    int          start_cyc [64];
    int          n_start = 0;
    int          done_cyc  [64];
    logic [23:0] done_data [64];
    int          n_done = 0;
    int          ack_who   [64];
    int          ack_cyc   [64];
    int          n_ack = 0;
    int          init_rise = -1;
    logic        init_q = 1'b0;
    logic        pend = 1'b0;
    logic        pend_nack = 1'b0;
    int          due = 0;

    // Model controls (written only by stimulus)
    logic        silent = 1'b0;
    logic [23:0] nack_frame = 24'h000000;
    int          nack_max = 0;
    int          nack_base = 0;

    always @(negedge clk) begin
        int occ;
        cyc++;
        bus.i_tx_done = 1'b0;
        bus.i_tx_nack = 1'b0;
        if (bus.o_ack != 2'b00 && n_ack < 64) begin
            ack_who[n_ack] = bus.o_ack[1] ? 1 : 0;
            ack_cyc[n_ack] = cyc;
            n_ack++;
        end
        if (!rst_n) begin
            pend   = 1'b0;
            init_q = 1'b0;
        end else begin
            if (init_done && !init_q) init_rise = cyc;
            init_q = init_done;
            if (pend && !silent && cyc == due) begin
                bus.i_tx_done = 1'b1;
                bus.i_tx_nack = pend_nack;
                pend = 1'b0;
                if (n_done < 64) begin
                    done_cyc[n_done]  = cyc;
                    done_data[n_done] = bus.o_tx_data;
                    n_done++;
                end
            end
            if (bus.o_tx_start && n_start < 64) begin
                frame_log[n_start] = bus.o_tx_data;
                start_cyc[n_start] = cyc;
                occ = 0;
                for (int i = nack_base; i <= n_start; i++)
                    if (frame_log[i] == nack_frame) occ++;
                n_start++;
                pend      = 1'b1;
                due       = cyc + LAT;
                pend_nack = (bus.o_tx_data == nack_frame) && (occ <= nack_max);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        tick(1);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic pulse_start();
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_init(input string tag, input int budget);
        int k = 0;
        while (!init_done && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, {31'd0, init_done}, 32'd1);
    endtask

    task automatic wait_nstart(input string tag, input int target, input int budget);
        int k = 0;
        while (n_start < target && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, (n_start >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_nack(input string tag, input int target, input int budget);
        int k = 0;
        while (n_ack < target && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, (n_ack >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    logic [23:0] init_exp [7];
    int sb, db, ab, c0;

    initial begin
        init_exp[0] = 24'h341E00; init_exp[1] = 24'h340815;
        init_exp[2] = 24'h340A00; init_exp[3] = 24'h340C00;
        init_exp[4] = 24'h340E42; init_exp[5] = 24'h341019;
        init_exp[6] = 24'h341201;
        bus.i_req = 2'b00;
        bus.i_req_data0 = 16'h0000;
        bus.i_req_data1 = 16'h0000;

        // Reset state
        tick(2);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ack", {30'd0, bus.o_ack}, 32'd0);
        chk("rst_tx_start", {31'd0, bus.o_tx_start}, 32'd0);
        chk("rst_tx_data", {8'd0, bus.o_tx_data}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Clean init sequence; requests held during init must wait
        sb = n_start; db = n_done; ab = n_ack;
        bus.i_req_data0 = {7'h02, 9'h079};
        bus.i_req = 2'b01;
        pulse_start();
        chk("init_busy", {31'd0, busy}, 32'd1);
        bus.i_req = 2'b00;
        wait_init("init_reached", 2000);
        chk("init_nframes", n_start - sb, 7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("init_frame%0d", i), {8'd0, frame_log[sb+i]}, {8'd0, init_exp[i]});
            chk($sformatf("init_stable%0d", i), {8'd0, done_data[db+i]}, {8'd0, init_exp[i]});
        end
        for (int i = 1; i < 7; i++)
            chk($sformatf("init_gap%0d", i), start_cyc[sb+i] - done_cyc[db+i-1], 7);
        chk("init_done_lat", init_rise - done_cyc[db+6], 2);
        chk("init_no_ack", n_ack - ab, 0);
        chk("init_err", {31'd0, err}, 32'd0);
        tick(6);
        chk("ready_busy", {31'd0, busy}, 32'd0);

        // Runtime: both requesters held -> 0,1,0,1
        sb = n_start; db = n_done; ab = n_ack;
        bus.i_req_data0 = {7'h02, 9'h079};
        bus.i_req_data1 = {7'h05, 9'h008};
        c0 = cyc;
        bus.i_req = 2'b11;
        wait_nack("rr_reached", ab + 4, 2000);
        bus.i_req = 2'b00;
        chk("rr_start_lat", start_cyc[sb] - c0, 2);
        chk("rr_ack_lat", ack_cyc[ab] - done_cyc[db], 2);
        chk("rr_frame0", {8'd0, frame_log[sb+0]}, 32'h00340479);
        chk("rr_frame1", {8'd0, frame_log[sb+1]}, 32'h00340A08);
        chk("rr_frame2", {8'd0, frame_log[sb+2]}, 32'h00340479);
        chk("rr_frame3", {8'd0, frame_log[sb+3]}, 32'h00340A08);
        chk("rr_ack0", ack_who[ab+0], 0);
        chk("rr_ack1", ack_who[ab+1], 1);
        chk("rr_ack2", ack_who[ab+2], 0);
        chk("rr_ack3", ack_who[ab+3], 1);
        tick(8);

        // Silent transmitter: timeout, two retries, error + ack
        sb = n_start; ab = n_ack;
        silent = 1'b1;
        bus.i_req = 2'b01;
        wait_nack("tmo_reached", ab + 1, 5000);
        bus.i_req = 2'b00;
        silent = 1'b0;
        chk("tmo_nframes", n_start - sb, 3);
        chk("tmo_frame0", {8'd0, frame_log[sb+0]}, 32'h00340479);
        chk("tmo_frame2", {8'd0, frame_log[sb+2]}, 32'h00340479);
        chk("tmo_spacing1", (start_cyc[sb+1] - start_cyc[sb] >= 1024) ? 32'd1 : 32'd0, 32'd1);
        chk("tmo_spacing2", (start_cyc[sb+2] - start_cyc[sb+1] >= 1024) ? 32'd1 : 32'd0, 32'd1);
        chk("tmo_ack_who", ack_who[ab], 0);
        chk("tmo_err", {31'd0, err}, 32'd1);

        // NACK the 3rd init frame once
        nack_frame = 24'h340A00; nack_max = 1; nack_base = n_start;
        do_reset();
        chk("nack1_err_cleared", {31'd0, err}, 32'd0);
        sb = n_start;
        pulse_start();
        wait_init("nack1_reached", 2000);
        chk("nack1_nframes", n_start - sb, 8);
        chk("nack1_frame2", {8'd0, frame_log[sb+2]}, 32'h00340A00);
        chk("nack1_frame3", {8'd0, frame_log[sb+3]}, 32'h00340A00);
        chk("nack1_frame7", {8'd0, frame_log[sb+7]}, 32'h00341201);
        chk("nack1_err", {31'd0, err}, 32'd0);

        // Always NACK 34_0E42: three attempts, error, init carries on
        nack_frame = 24'h340E42; nack_max = 1000; nack_base = n_start;
        do_reset();
        sb = n_start;
        pulse_start();
        wait_init("nack3_reached", 2000);
        chk("nack3_nframes", n_start - sb, 9);
        chk("nack3_frame4", {8'd0, frame_log[sb+4]}, 32'h00340E42);
        chk("nack3_frame5", {8'd0, frame_log[sb+5]}, 32'h00340E42);
        chk("nack3_frame6", {8'd0, frame_log[sb+6]}, 32'h00340E42);
        chk("nack3_frame7", {8'd0, frame_log[sb+7]}, 32'h00341019);
        chk("nack3_frame8", {8'd0, frame_log[sb+8]}, 32'h00341201);
        chk("nack3_err", {31'd0, err}, 32'd1);
        tick(8);

        // Reset in the middle of a runtime frame's WAIT
        nack_frame = 24'h000000; nack_max = 0; nack_base = n_start;
        sb = n_start;
        bus.i_req_data0 = {7'h02, 9'h079};
        bus.i_req = 2'b01;
        wait_nstart("mid_started", sb + 1, 100);
        tick(10);
        ab = n_ack;
        rst_n = 1'b0;
        #1;
        chk("mid_init_done", {31'd0, init_done}, 32'd0);
        chk("mid_err", {31'd0, err}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_tx_start", {31'd0, bus.o_tx_start}, 32'd0);
        chk("mid_tx_data", {8'd0, bus.o_tx_data}, 32'd0);
        chk("mid_ack", {30'd0, bus.o_ack}, 32'd0);
        bus.i_req = 2'b00;
        tick(LAT + 4);
        chk("mid_no_ack", n_ack - ab, 0);
        rst_n = 1'b1;
        tick(2);
        chk("mid_idle_busy", {31'd0, busy}, 32'd0);
        sb = n_start;
        pulse_start();
        wait_nstart("reinit_started", sb + 1, 100);
        chk("reinit_frame0", {8'd0, frame_log[sb]}, 32'h00341E00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
